// File: rtl/shbuf_arb_pkg.sv
// Shared FSM state type and round-robin helper for the shift buffer arbiter.
package shbuf_arb_pkg;

   typedef enum logic [1:0] {IDLE, BURST, PAD} state_e;

   // Requester after id, wrapping at n.
   function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
      return (id + 1 >= n) ? 0 : id + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i wins.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IdW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IdW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IdW-1:0]     gnt_id_o
);

   always_comb begin
      logic [IdW-1:0] idx;
      logic           found;
      gnt_o    = '0;
      gnt_id_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = IdW'((32'(ptr_i) + k) % NUM_REQ);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_id_o   = idx;
         end
      end
   end

endmodule

// File: rtl/shift_buffer_arbiter.sv
// Round-robin owner of a shared word-to-line shift buffer; tags each completed line.
// Define SHBUF_ARB_TIMEOUT_EN to zero-pad lines whose owner stalls for TIMEOUT_CYC cycles.
module shift_buffer_arbiter
   import shbuf_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned BUF_SIZE    = 8,
   parameter int unsigned BUF_WIDTH   = 32,
   parameter int unsigned TIMEOUT_CYC = 16,
   localparam int unsigned IdW = $clog2(NUM_REQ)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req_i,
   input  logic [NUM_REQ-1:0]           valid_i,
   input  logic [NUM_REQ*BUF_WIDTH-1:0] data_i,
   output logic [NUM_REQ-1:0]           ready_o,
   output logic [BUF_WIDTH-1:0]         buf_data_o,
   output logic                         buf_wr_en_o,
   input  logic                         buf_valid_i,
   output logic [IdW-1:0]               tag_id_o,
   output logic                         tag_pad_o,
   output logic                         align_err_o
);

   localparam int unsigned CntW = $clog2(BUF_SIZE) + 1;

   typedef logic [IdW-1:0] id_t;
   typedef struct packed {
      id_t  id;
      logic pad;
   } tag_t;

   state_e          state_q;
   id_t             owner_q, ptr_q;
   logic [CntW-1:0] cnt_q;
   tag_t            tag_q;
   logic            expect_q, align_err_q;
`ifdef SHBUF_ARB_TIMEOUT_EN
   localparam int unsigned StallW = $clog2(TIMEOUT_CYC) + 1;
   logic [StallW-1:0] stall_q;
`endif

   logic [NUM_REQ-1:0]   gnt;
   id_t                  gnt_id;
   logic [BUF_WIDTH-1:0] words [NUM_REQ];
   logic                 last_beat;
   id_t                  next_ptr;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_rr (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .gnt_o   (gnt),
      .gnt_id_o(gnt_id)
   );

   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) words[i] = data_i[i*BUF_WIDTH +: BUF_WIDTH];
   end

   assign last_beat = (cnt_q == CntW'(BUF_SIZE - 1));
   assign next_ptr  = IdW'(rr_next(32'(owner_q), NUM_REQ));

   always_comb begin
      ready_o     = '0;
      buf_wr_en_o = 1'b0;
      buf_data_o  = '0;
      if (state_q == BURST) begin
         ready_o[owner_q] = 1'b1;
         buf_wr_en_o      = valid_i[owner_q];
         buf_data_o       = words[owner_q];
      end else if (state_q == PAD) begin
         buf_wr_en_o = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         ptr_q       <= '0;
         cnt_q       <= '0;
         tag_q       <= '0;
         expect_q    <= 1'b0;
         align_err_q <= 1'b0;
`ifdef SHBUF_ARB_TIMEOUT_EN
         stall_q     <= '0;
`endif
      end else begin
         // The buffer must report line-complete exactly one cycle after the last write.
         expect_q <= 1'b0;
         if (buf_valid_i != expect_q) align_err_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (|gnt) begin
                  owner_q <= gnt_id;
                  cnt_q   <= '0;
                  state_q <= BURST;
               end
            end
            BURST: begin
               if (valid_i[owner_q]) begin
`ifdef SHBUF_ARB_TIMEOUT_EN
                  stall_q <= '0;
`endif
                  if (last_beat) begin
                     cnt_q    <= '0;
                     tag_q    <= '{id: owner_q, pad: 1'b0};
                     ptr_q    <= next_ptr;
                     expect_q <= 1'b1;
                     state_q  <= IDLE;
                  end else begin
                     cnt_q <= cnt_q + CntW'(1);
                  end
               end
`ifdef SHBUF_ARB_TIMEOUT_EN
               else if (cnt_q != '0) begin
                  if (stall_q == StallW'(TIMEOUT_CYC - 1)) begin
                     stall_q <= '0;
                     state_q <= PAD;
                  end else begin
                     stall_q <= stall_q + StallW'(1);
                  end
               end
`endif
            end
`ifdef SHBUF_ARB_TIMEOUT_EN
            PAD: begin
               if (last_beat) begin
                  cnt_q    <= '0;
                  tag_q    <= '{id: owner_q, pad: 1'b1};
                  ptr_q    <= next_ptr;
                  expect_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CntW'(1);
               end
            end
`endif
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tag_id_o    = tag_q.id;
   assign tag_pad_o   = tag_q.pad;
   assign align_err_o = align_err_q;

endmodule

// File: tb/tb_shift_buffer_arbiter.sv
// Randomized bench for shift_buffer_arbiter against a burst-level reference model.
module tb_shift_buffer_arbiter;

   localparam int N = 4;
   localparam int S = 8;
   localparam int W = 32;
   localparam int T = 16;
`ifdef SHBUF_ARB_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_i = '0;
   logic [N-1:0]   valid_i = '0;
   logic [N*W-1:0] data_i = '0;
   logic [N-1:0]   ready_o;
   logic [W-1:0]   buf_data_o;
   logic           buf_wr_en_o;
   logic           buf_valid_i = 1'b0;
   logic [1:0]     tag_id_o;
   logic           tag_pad_o;
   logic           align_err_o;

   shift_buffer_arbiter #(
      .NUM_REQ    (N),
      .BUF_SIZE   (S),
      .BUF_WIDTH  (W),
      .TIMEOUT_CYC(T)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req_i),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .ready_o    (ready_o),
      .buf_data_o (buf_data_o),
      .buf_wr_en_o(buf_wr_en_o),
      .buf_valid_i(buf_valid_i),
      .tag_id_o   (tag_id_o),
      .tag_pad_o  (tag_pad_o),
      .align_err_o(align_err_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the buffer, how many words of the line are done.
   int     m_owner, m_ptr, m_beats, m_stall, m_tag_id;
   bit     m_pad, m_tag_pad, m_expect, m_err;
   int     dut_writes;
   int     dut_grants[$];
   logic [N-1:0] prev_ready, last_ready;
   logic         last_wr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_beats = 0; m_stall = 0; m_pad = 0;
      m_tag_id = 0; m_tag_pad = 0; m_expect = 0; m_err = 0;
      dut_writes = 0; prev_ready = '0;
   endtask

   task automatic finish_line(input bit pad);
      check("line_writes", 64'(dut_writes), 64'(S));
      dut_writes = 0;
      m_tag_id   = m_owner;
      m_tag_pad  = pad;
      m_ptr      = (m_owner + 1) % N;
      m_owner    = -1;
      m_expect   = 1;
   endtask

   task automatic model_tick(input bit rst, input logic [N-1:0] req, input logic [N-1:0] val,
                             input bit bv);
      if (!rst) begin
         model_reset();
         return;
      end
      if (bv != m_expect) m_err = 1;
      m_expect = 0;
      if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int c = (m_ptr + k) % N;
            if (req[c]) begin
               m_owner = c; m_beats = 0; m_stall = 0; m_pad = 0;
               break;
            end
         end
      end else if (m_pad) begin
         m_beats++;
         if (m_beats == S) finish_line(1);
      end else if (val[m_owner]) begin
         m_beats++;
         m_stall = 0;
         if (m_beats == S) finish_line(0);
      end else if (TimeoutEn && m_beats > 0) begin
         m_stall++;
         if (m_stall == T) begin
            m_pad = 1; m_stall = 0;
         end
      end
   endtask

   task automatic check_outputs(input logic [N-1:0] val, input logic [N*W-1:0] d);
      logic [N-1:0] e_ready = '0;
      logic         e_wr = 1'b0;
      logic [W-1:0] e_data = '0;
      if (m_owner >= 0) begin
         if (m_pad) e_wr = 1'b1;
         else begin
            e_ready[m_owner] = 1'b1;
            e_wr             = val[m_owner];
            e_data           = d[m_owner*W +: W];
         end
      end
      check("ready", 64'(ready_o), 64'(e_ready));
      check("wr_en", 64'(buf_wr_en_o), 64'(e_wr));
      if (e_wr) check("data", 64'(buf_data_o), 64'(e_data));
      check("tag_id", 64'(tag_id_o), 64'(m_tag_id));
      check("tag_pad", 64'(tag_pad_o), 64'(m_tag_pad));
      check("align_err", 64'(align_err_o), 64'(m_err));
      if (buf_wr_en_o) dut_writes++;
      if (ready_o != '0 && prev_ready == '0)
         for (int i = 0; i < N; i++) if (ready_o[i]) dut_grants.push_back(i);
      prev_ready = ready_o;
      last_ready = ready_o;
      last_wr    = buf_wr_en_o;
   endtask

   function automatic logic [N*W-1:0] rnd_data();
      logic [N*W-1:0] d;
      for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
      return d;
   endfunction

   task automatic step(input bit rst, input logic [N-1:0] req, input logic [N-1:0] val,
                       input bit inj, input logic [N*W-1:0] d);
      bit bv;
      @(negedge clk);
      bv          = m_expect | inj;
      rst_n       = rst;
      req_i       = req;
      valid_i     = val;
      data_i      = d;
      buf_valid_i = bv;
      #1;
      check_outputs(val, d);
      @(posedge clk);
      model_tick(rst, req, val, bv);
   endtask

   task automatic drain();
      int n = 0;
      while ((m_owner >= 0 || m_expect) && n < 60) begin
         step(1, '0, '1, 0, rnd_data());
         n++;
      end
      if (m_owner >= 0 || m_expect) check("drain_timeout", 64'(n), 64'(0));
      step(1, '0, '0, 0, rnd_data());
   endtask

   initial begin
      int span, pads;
      logic [N*W-1:0] d;
      int exp_order[5] = '{0, 1, 2, 3, 0};

      repeat (3) @(posedge clk);
      model_reset();
      step(1, '0, '0, 0, '0);  // reset state

      // Lone requester 0, words 1..8 every cycle.
      step(1, 4'b0001, '0, 0, rnd_data());
      for (int k = 0; k < S; k++) begin
         d = rnd_data();
         d[W-1:0] = W'(k + 1);
         step(1, '0, 4'b0001, 0, d);
      end
      step(1, '0, '0, 0, rnd_data());
      check("t1_tag_id", 64'(tag_id_o), 64'(0));
      check("t1_ready_dropped", 64'(last_ready), 64'(0));

      // All requesters held from reset: rotation 0,1,2,3,0.
      step(0, 4'b1111, '0, 0, rnd_data());
      dut_grants.delete();
      for (int k = 0; k < 50; k++) step(1, 4'b1111, 4'b1111, 0, rnd_data());
      check("t2_grant_count_ok", 64'(dut_grants.size() >= 5), 64'(1));
      for (int k = 0; k < 5 && k < dut_grants.size(); k++)
         check("t2_grant_order", 64'(dut_grants[k]), 64'(exp_order[k]));
      drain();

      // Owner 2 with alternating valid: 8 words over 15 cycles.
      step(1, 4'b0100, '0, 0, rnd_data());
      span = 0;
      for (int k = 0; k < 20; k++) begin
         step(1, '0, (k % 2 == 0) ? 4'b0100 : 4'b0000, 0, rnd_data());
         if (last_ready[2]) span++;
      end
      check("t3_span", 64'(span), 64'(15));
      drain();

      // Reset at beat 4 discards the line and rewinds the pointer.
      step(1, 4'b0001, '0, 0, rnd_data());
      for (int k = 0; k < 4; k++) step(1, '0, 4'b0001, 0, rnd_data());
      step(0, '0, 4'b0001, 0, rnd_data());
      dut_grants.delete();
      step(1, 4'b1111, '0, 0, rnd_data());
      check("t5_idle_ready", 64'(last_ready), 64'(0));
      step(1, 4'b1111, '0, 0, rnd_data());
      step(1, '0, '0, 0, rnd_data());
      if (dut_grants.size() == 0) check("t5_grant_seen", 64'(0), 64'(1));
      else check("t5_first_grant", 64'(dut_grants[0]), 64'(0));
      drain();

`ifdef SHBUF_ARB_TIMEOUT_EN
      // Requester 1 sends 3 words then stalls: 5 padded writes follow.
      step(1, 4'b0010, '0, 0, rnd_data());
      for (int k = 0; k < 3; k++) step(1, '0, 4'b0010, 0, rnd_data());
      pads = 0;
      for (int k = 0; k < 25; k++) begin
         step(1, '0, '0, 0, rnd_data());
         if (last_wr && last_ready == '0) pads++;
      end
      check("t4_pad_writes", 64'(pads), 64'(5));
      check("t4_tag_id", 64'(tag_id_o), 64'(1));
      check("t4_tag_pad", 64'(tag_pad_o), 64'(1));
      drain();
`else
      pads = 0;
`endif

      // Random traffic with a well-behaved buffer.
      for (int k = 0; k < 800; k++) begin
         logic [N-1:0] v;
         for (int i = 0; i < N; i++) v[i] = ($urandom_range(3) != 0);
         step(1, N'($urandom), v, 0, rnd_data());
      end
      drain();

      // Spurious line-complete in IDLE: sticky error until reset.
      step(1, '0, '0, 1, rnd_data());
      for (int k = 0; k < 100; k++) step(1, N'($urandom), '1, 0, rnd_data());
      check("t6_align_sticky", 64'(align_err_o), 64'(1));
      step(0, '0, '0, 0, rnd_data());
      step(1, '0, '0, 0, rnd_data());
      check("t6_align_cleared", 64'(align_err_o), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
